// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control unit <-> datapath/memory signal bundle
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        Zero;
  logic        mem_ready;
  logic        PCSrc;
  logic        ALUSrc;
  logic        RegWrite;
  logic        MemToReg;
  logic [3:0]  ALUCtrl;
  logic        loadPC;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  state;

  modport master (
    input  instr, Zero, mem_ready,
    output PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC, MemRead, MemWrite, state
  );

  modport slave (
    output instr, Zero, mem_ready,
    input  PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC, MemRead, MemWrite, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - five-state multicycle RV32I-subset control FSM
// Optional retired-instruction counter enabled by CTRL_PERF_CNT_EN.
module multicycle_ctrl (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  bus
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]        instret
`endif
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  state_t     state_q, state_d;
  logic       zero_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r, is_i, is_lw, is_sw, is_beq, legal;
  logic [3:0] alu_ctrl;

  logic       unused_instr_bits;
  assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  // Decode is purely combinational on instr so the datapath sees it in every state.
  always_comb begin
    opcode   = bus.instr[6:0];
    funct3   = bus.instr[14:12];
    is_r     = (opcode == OP_R);
    is_i     = (opcode == OP_I);
    is_lw    = (opcode == OP_LW);
    is_sw    = (opcode == OP_SW);
    is_beq   = (opcode == OP_BEQ);
    legal    = ((is_r || is_i) && (funct3 != 3'b011)) || is_lw || is_sw ||
               (is_beq && (funct3 == 3'b000));
    alu_ctrl = ALU_ADD;
    if (legal && (is_r || is_i)) begin
      case (funct3)
        3'b000:  alu_ctrl = (is_r && bus.instr[30]) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_ctrl = ALU_SLL;
        3'b010:  alu_ctrl = ALU_SLT;
        3'b100:  alu_ctrl = ALU_XOR;
        3'b101:  alu_ctrl = bus.instr[30] ? ALU_SRA : ALU_SRL;
        3'b110:  alu_ctrl = ALU_OR;
        3'b111:  alu_ctrl = ALU_AND;
        default: alu_ctrl = ALU_ADD;
      endcase
    end else if (legal && is_beq) begin
      alu_ctrl = ALU_SUB;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IF;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_EX) zero_q <= bus.Zero;
    end
  end

  always_comb begin
    state_d      = state_q;
    bus.ALUCtrl  = alu_ctrl;
    bus.ALUSrc   = is_i || is_lw || is_sw;
    bus.MemToReg = is_lw;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.RegWrite = 1'b0;
    bus.loadPC   = 1'b0;
    bus.PCSrc    = 1'b0;
    bus.state    = state_q;
    case (state_q)
      S_IF:  state_d = S_ID;
      S_ID:  state_d = S_EX;
      S_EX:  state_d = S_MEM;
      S_MEM: begin
        bus.MemRead  = is_lw;
        bus.MemWrite = is_sw;
        if (!(is_lw || is_sw) || bus.mem_ready) state_d = S_WB;
      end
      S_WB: begin
        bus.RegWrite = legal && (is_r || is_i || is_lw);
        bus.loadPC   = 1'b1;
        bus.PCSrc    = is_beq && zero_q && legal;
        state_d      = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] instret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= 32'd0;
    end else if (state_q == S_WB) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] instret;
`endif

  multicycle_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CTRL_PERF_CNT_EN
    ,
    .instret (instret)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  alu;
    logic        src;
    logic        m2r;
    int          rw;
    logic        pcs;
    int          mr;
    int          mw;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc, c_mr, c_mw, c_rw, retired;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: accumulate strobe cycles per instruction, score at the loadPC pulse.
  always @(negedge clk) begin
    if (rst) begin
      cyc = 0; c_mr = 0; c_mw = 0; c_rw = 0; retired = 0;
    end else begin
      cyc++;
      if (bus.MemRead)  c_mr++;
      if (bus.MemWrite) c_mw++;
      if (bus.RegWrite) c_rw++;
      if (bus.loadPC) begin
        if (sb.size() == 0) begin
          chk("unexpected_loadPC", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk($sformatf("state@%h", e.instr),    32'(bus.state),    32'd4);
          chk($sformatf("latency@%h", e.instr),  32'(cyc),          32'(e.lat));
          chk($sformatf("ALUCtrl@%h", e.instr),  32'(bus.ALUCtrl),  32'(e.alu));
          chk($sformatf("ALUSrc@%h", e.instr),   32'(bus.ALUSrc),   32'(e.src));
          chk($sformatf("MemToReg@%h", e.instr), 32'(bus.MemToReg), 32'(e.m2r));
          chk($sformatf("PCSrc@%h", e.instr),    32'(bus.PCSrc),    32'(e.pcs));
          chk($sformatf("RegWrite_cyc@%h", e.instr), 32'(c_rw), 32'(e.rw));
          chk($sformatf("MemRead_cyc@%h", e.instr),  32'(c_mr), 32'(e.mr));
          chk($sformatf("MemWrite_cyc@%h", e.instr), 32'(c_mw), 32'(e.mw));
          retired++;
        end
        cyc = 0; c_mr = 0; c_mw = 0; c_rw = 0;
      end
    end
  end

  task automatic run(input logic [31:0] instr, input logic zero, input int waits,
                     input logic [3:0] alu, input logic src, input logic m2r,
                     input int rw, input logic pcs, input int mr, input int mw,
                     input int lat);
    exp_t x;
    int   memcnt;
    bit   done;
    bus.instr = instr;
    x.instr = instr; x.alu = alu; x.src = src; x.m2r = m2r; x.rw = rw;
    x.pcs = pcs; x.mr = mr; x.mw = mw; x.lat = lat;
    sb.push_back(x);
    memcnt = 0;
    done   = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk); #2;
      if (bus.loadPC) done = 1'b1;
      bus.Zero = (bus.state == 3'd2) ? zero : ~zero;
      if (bus.state == 3'd3) begin
        memcnt++;
        bus.mem_ready = (memcnt > waits);
      end else begin
        bus.mem_ready = 1'b0;
      end
    end
    if (!done) chk($sformatf("timeout@%h", instr), 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    bus.instr = 32'h0000_0013;
    bus.Zero = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("rst_state",    32'(bus.state),    32'd0);
    chk("rst_RegWrite", 32'(bus.RegWrite), 32'd0);
    chk("rst_loadPC",   32'(bus.loadPC),   32'd0);
    chk("rst_PCSrc",    32'(bus.PCSrc),    32'd0);
    chk("rst_MemRead",  32'(bus.MemRead),  32'd0);
    chk("rst_MemWrite", 32'(bus.MemWrite), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    //   instr          Z  w  alu      src  m2r rw pcs mr mw lat
    run(32'h002081B3, 0, 2, 4'b0010, 0, 0, 1, 0, 0, 0, 5);  // add
    run(32'h0000A183, 0, 3, 4'b0010, 1, 1, 1, 0, 4, 0, 8);  // lw, 3 waits
    run(32'h00208463, 1, 0, 4'b0110, 0, 0, 0, 1, 0, 0, 5);  // beq taken
    run(32'h00208463, 0, 0, 4'b0110, 0, 0, 0, 0, 0, 0, 5);  // beq not taken
    run(32'h0020A023, 0, 0, 4'b0010, 1, 0, 0, 0, 0, 1, 5);  // sw, no wait
    run(32'h0000007F, 1, 0, 4'b0010, 0, 0, 0, 0, 0, 0, 5);  // illegal opcode
    run(32'h402081B3, 0, 0, 4'b0110, 0, 0, 1, 0, 0, 0, 5);  // sub
    run(32'h4030D193, 0, 0, 4'b1010, 1, 0, 1, 0, 0, 0, 5);  // srai
    run(32'h40008193, 0, 0, 4'b0010, 1, 0, 1, 0, 0, 0, 5);  // addi, bit30 ignored
    run(32'h0020B1B3, 0, 0, 4'b0010, 0, 0, 0, 0, 0, 0, 5);  // R funct3=011 illegal
    run(32'h00209463, 1, 0, 4'b0010, 0, 0, 0, 0, 0, 0, 5);  // bne illegal
    run(32'h0020C1B3, 0, 0, 4'b1101, 0, 0, 1, 0, 0, 0, 5);  // xor
    run(32'h0020E1B3, 0, 0, 4'b0001, 0, 0, 1, 0, 0, 0, 5);  // or
    run(32'h0020F1B3, 0, 0, 4'b0000, 0, 0, 1, 0, 0, 0, 5);  // and
    run(32'h002091B3, 0, 0, 4'b1001, 0, 0, 1, 0, 0, 0, 5);  // sll
    run(32'h0020A1B3, 0, 0, 4'b0111, 0, 0, 1, 0, 0, 0, 5);  // slt
    run(32'h0020D1B3, 0, 0, 4'b1000, 0, 0, 1, 0, 0, 0, 5);  // srl
    run(32'h0000A183, 0, 0, 4'b0010, 1, 1, 1, 0, 1, 0, 5);  // lw, no wait
    run(32'h0020A023, 0, 2, 4'b0010, 1, 0, 0, 0, 0, 3, 7);  // sw, 2 waits

    // Store stalled in MEM, then asynchronous reset mid-cycle.
    bus.instr = 32'h0020A023;
    bus.mem_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #2;
      if (bus.state == 3'd3) break;
    end
    @(negedge clk); #2;
    chk("stall_MemWrite", 32'(bus.MemWrite), 32'd1);
    chk("stall_state",    32'(bus.state),    32'd3);
    #1 rst = 1'b1;
    #1;
    chk("abort_MemWrite", 32'(bus.MemWrite), 32'd0);
    chk("abort_state",    32'(bus.state),    32'd0);
    chk("abort_loadPC",   32'(bus.loadPC),   32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run(32'h002081B3, 0, 0, 4'b0010, 0, 0, 1, 0, 0, 0, 5);
    run(32'h0000007F, 0, 0, 4'b0010, 0, 0, 0, 0, 0, 0, 5);
    run(32'h0020A023, 0, 1, 4'b0010, 1, 0, 0, 0, 0, 2, 6);
`ifdef CTRL_PERF_CNT_EN
    @(posedge clk); #1;
    chk("instret_3", instret, 32'd3);
    force dut.instret_q = 32'hFFFF_FFFF;
    #1 release dut.instret_q;
    run(32'h002081B3, 0, 0, 4'b0010, 0, 0, 1, 0, 0, 0, 5);
    @(posedge clk); #1;
    chk("instret_wrap", instret, 32'd0);
`endif
    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("retired_since_rst", 32'(retired),
`ifdef CTRL_PERF_CNT_EN
        32'd4
`else
        32'd3
`endif
    );
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
